mac9_accum_addertree: RTL and testbench

Reduction back-end of a 3x3 convolution MAC lane.
- Sums nine signed 8x8 products, a 16-bit bias and the previous 13-bit partial output scaled by 2^6.
- Uses a carry-save adder tree (stage 1, stage 2) followed by a final carry-propagate adder.
- Produces a 14-bit overflow-flagged result and a 13-bit saturated result, registered once.
- Sits between the 9-lane multiplier array and the output/accumulation buffer.

---
 rtl/mac9_accum_addertree_pkg.sv | 35 +++
 rtl/mac9_accum_addertree_csa_3to2.sv | 26 ++
 rtl/mac9_accum_addertree.sv | 138 +++++++++++++
 tb/tb_mac9_accum_addertree.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mac9_accum_addertree_pkg.sv
// Shared constants and helpers for the 3x3 convolution MAC reduction back-end.
// Holds the datapath widths, the saturation limits, the overflow codes carried
// on out[13:12], and small helpers used by the adder tree and the final adder.
package mac9_accum_addertree_pkg;

  localparam int N_PROD = 9;   // products summed per result
  localparam int PROD_W = 16;  // width of one signed product
  localparam int SHIFT  = 6;   // pre_output scaling and LSBs dropped from the sum
  localparam int SUM_W  = 20;  // exact internal sum width
  localparam int OUT_W  = 14;  // width of the overflow-flagged result
  localparam int SAT_W  = 13;  // width of the saturated result and of pre_output

  localparam logic [SAT_W-1:0] SAT_MAX = 13'h0FFF;  // +4095
  localparam logic [SAT_W-1:0] SAT_MIN = 13'h1000;  // -4096

  localparam logic [1:0] OVF_POS = 2'b01;
  localparam logic [1:0] OVF_NEG = 2'b10;

  // Sign-extend a 16-bit operand (product or bias) to the internal sum width.
  function automatic logic [SUM_W-1:0] sext16(input logic [PROD_W-1:0] v);
    return {{(SUM_W-PROD_W){v[PROD_W-1]}}, v};
  endfunction

  // Carry out of the dropped low bits of the final addition. Only this carry
  // reaches the kept bits, so the low sum bits are never formed.
  function automatic logic low_carry(input logic [SHIFT-1:0] a, input logic [SHIFT-1:0] b);
    logic c;
    c = 1'b0;
    for (int i = 0; i < SHIFT; i++) begin
      c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    return c;
  endfunction

endpackage

// File: rtl/mac9_accum_addertree_csa_3to2.sv
// One row of full adders compressing three operands into a sum and a carry
// vector with a + b + c == sum_o + carry_o (modulo 2^W).
// Ports:
//   a_i, b_i, c_i : three W-bit operands
//   sum_o         : bitwise XOR of the operands
//   carry_o       : bitwise majority, shifted up by one position
module csa_3to2 #(
  parameter int W = 20
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  output logic [W-1:0] sum_o,
  output logic [W-1:0] carry_o
);

  assign sum_o = a_i ^ b_i ^ c_i;

  // The majority of the top bit would land outside the word, so it is never
  // formed; the enclosing sum is guaranteed not to wrap.
  assign carry_o[0]     = 1'b0;
  assign carry_o[W-1:1] = (a_i[W-2:0] & b_i[W-2:0]) |
                          (a_i[W-2:0] & c_i[W-2:0]) |
                          (b_i[W-2:0] & c_i[W-2:0]);

endmodule

// File: rtl/mac9_accum_addertree.sv
// Reduction back-end of a 3x3 convolution MAC lane.
// Sums nine signed products, a signed bias and the previous partial output
// scaled by 64 through a carry-save tree and one carry-propagate adder, drops
// the six LSBs (floor divide by 64) and registers both the overflow-flagged
// result and its saturated form.
// Ports:
//   clk        : system clock, rising edge
//   reset      : asynchronous active-low reset
//   in_valid   : qualifies products/bias/pre_output this cycle
//   products   : nine signed 16-bit products, product k in [16k+15:16k]
//   bias       : signed 16-bit bias
//   pre_output : signed 13-bit previous partial output
//   out_valid  : out/out_sat hold a new result
//   out        : sum[19:6]; out[13:12] = 01 pos overflow, 10 neg overflow
//   out_sat    : result saturated to [-4096, 4095]
module mac9_accum_addertree
  import mac9_accum_addertree_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [N_PROD*PROD_W-1:0] products,
  input  logic [PROD_W-1:0]        bias,
  input  logic [SAT_W-1:0]         pre_output,
  output logic                     out_valid,
  output logic [OUT_W-1:0]         out,
  output logic [SAT_W-1:0]         out_sat
);

  logic [SUM_W-1:0] prodExt [N_PROD];
  logic [SUM_W-1:0] biasExt;
  logic [SUM_W-1:0] preExt;

  for (genvar k = 0; k < N_PROD; k++) begin : g_ext
    assign prodExt[k] = sext16(products[k*PROD_W +: PROD_W]);
  end

  assign biasExt = sext16(bias);
  assign preExt  = {pre_output[SAT_W-1], pre_output, {SHIFT{1'b0}}};

  // Stage 1: the nine products, three at a time, into six vectors.
  logic [SUM_W-1:0] s1Sum [3];
  logic [SUM_W-1:0] s1Car [3];

  for (genvar g = 0; g < 3; g++) begin : g_stage1
    csa_3to2 #(.W(SUM_W)) u_csa (
      .a_i    (prodExt[3*g]),
      .b_i    (prodExt[3*g+1]),
      .c_i    (prodExt[3*g+2]),
      .sum_o  (s1Sum[g]),
      .carry_o(s1Car[g])
    );
  end

  // Stage 2: six product vectors into four.
  logic [SUM_W-1:0] s2Sum [2];
  logic [SUM_W-1:0] s2Car [2];

  csa_3to2 #(.W(SUM_W)) u_s2a (
    .a_i(s1Sum[0]), .b_i(s1Car[0]), .c_i(s1Sum[1]),
    .sum_o(s2Sum[0]), .carry_o(s2Car[0])
  );

  csa_3to2 #(.W(SUM_W)) u_s2b (
    .a_i(s1Car[1]), .b_i(s1Sum[2]), .c_i(s1Car[2]),
    .sum_o(s2Sum[1]), .carry_o(s2Car[1])
  );

  // Remaining layers fold in bias and the scaled feedback and bring the
  // six-vector set (four + bias + pre) down to two.
  logic [SUM_W-1:0] s3Sum [2];
  logic [SUM_W-1:0] s3Car [2];
  logic [SUM_W-1:0] s4Sum, s4Car;
  logic [SUM_W-1:0] finSum, finCar;

  csa_3to2 #(.W(SUM_W)) u_s3a (
    .a_i(s2Sum[0]), .b_i(s2Car[0]), .c_i(s2Sum[1]),
    .sum_o(s3Sum[0]), .carry_o(s3Car[0])
  );

  csa_3to2 #(.W(SUM_W)) u_s3b (
    .a_i(s2Car[1]), .b_i(biasExt), .c_i(preExt),
    .sum_o(s3Sum[1]), .carry_o(s3Car[1])
  );

  csa_3to2 #(.W(SUM_W)) u_s4 (
    .a_i(s3Sum[0]), .b_i(s3Car[0]), .c_i(s3Sum[1]),
    .sum_o(s4Sum), .carry_o(s4Car)
  );

  csa_3to2 #(.W(SUM_W)) u_s5 (
    .a_i(s4Sum), .b_i(s4Car), .c_i(s3Car[1]),
    .sum_o(finSum), .carry_o(finCar)
  );

  // Final carry-propagate add over the kept bits only; the dropped LSBs
  // contribute just their carry-out, which gives floor(sum / 64).
  logic             loCarry;
  logic [OUT_W-1:0] out_d;
  logic [SAT_W-1:0] out_sat_d;

  assign loCarry = low_carry(finSum[SHIFT-1:0], finCar[SHIFT-1:0]);
  assign out_d   = finSum[SUM_W-1:SHIFT] + finCar[SUM_W-1:SHIFT] + {{(OUT_W-1){1'b0}}, loCarry};

  // Saturation keyed off the two top bits of the truncated result.
  always_comb begin
    out_sat_d = out_d[SAT_W-1:0];
    case (out_d[OUT_W-1:OUT_W-2])
      OVF_POS: out_sat_d = SAT_MAX;
      OVF_NEG: out_sat_d = SAT_MIN;
      default: out_sat_d = out_d[SAT_W-1:0];
    endcase
  end

  // Output register: results load only on valid cycles and otherwise hold.
  logic             out_valid_q;
  logic [OUT_W-1:0] out_q;
  logic [SAT_W-1:0] out_sat_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      out_sat_q   <= '0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        out_q     <= out_d;
        out_sat_q <= out_sat_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_mac9_accum_addertree.sv
// Testbench for mac9_accum_addertree: directed patterns, a full int8-pair
// sweep, valid gaps and asynchronous reset, checked against a scoreboard fed
// by an independent integer reference model.
module tb_mac9_accum_addertree;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [143:0]  products;
  logic [15:0]   bias;
  logic [12:0]   pre_output;
  logic          out_valid;
  logic [13:0]   out;
  logic [12:0]   out_sat;

  typedef struct packed {
    logic [13:0] o;
    logic [12:0] s;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  mac9_accum_addertree dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .products  (products),
    .bias      (bias),
    .pre_output(pre_output),
    .out_valid (out_valid),
    .out       (out),
    .out_sat   (out_sat)
  );

  // 10-time-unit clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Integer reference: exact sum, floor division by 64, saturation by value.
  function automatic exp_t model(input logic [143:0] p, input logic [15:0] b, input logic [12:0] pre);
    int   s;
    int   q;
    exp_t e;
    s = 0;
    for (int k = 0; k < 9; k++) s += int'($signed(p[k*16 +: 16]));
    s += int'($signed(b));
    s += int'($signed(pre)) * 64;
    q = s / 64;
    if (s < 0 && (s % 64) != 0) q = q - 1;
    e.o = q[13:0];
    if (s > 262143)       e.s = 13'h0FFF;
    else if (s < -262144) e.s = 13'h1000;
    else                  e.s = q[12:0];
    return e;
  endfunction

  // Drive one input vector and record its expected result when valid.
  task automatic drive_vec(input logic v, input logic [143:0] p, input logic [15:0] b, input logic [12:0] pre);
    in_valid   = v;
    products   = p;
    bias       = b;
    pre_output = pre;
    if (v) sb.push_back(model(p, b, pre));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive_vec(1'b0, '0, '0, '0);
    #12;
    checks++;
    if (out_valid !== 1'b0 || out !== 14'h0 || out_sat !== 13'h0) begin
      errors++;
      $display("[TB] FAIL reset_state: got valid=%b out=%h sat=%h, want 0/0/0", out_valid, out, out_sat);
    end
    step();
    reset = 1'b1;
  endtask

  task automatic test_directed();
    logic [143:0] pTab [8];
    logic [15:0]  bTab [8];
    logic [12:0]  rTab [8];
    logic [13:0]  oTab [8];
    logic [12:0]  sTab [8];
    exp_t         e;
    pTab[0] = '0;                    bTab[0] = 16'h0000; rTab[0] = 13'h0000; oTab[0] = 14'h0000; sTab[0] = 13'h0000;
    pTab[1] = {9{16'h4000}};         bTab[1] = 16'h0000; rTab[1] = 13'h0000; oTab[1] = 14'h0900; sTab[1] = 13'h0900;
    pTab[2] = {9{16'h4000}};         bTab[2] = 16'h7FFF; rTab[2] = 13'h0FFF; oTab[2] = 14'h1AFE; sTab[2] = 13'h0FFF;
    pTab[3] = {9{16'hC080}};         bTab[3] = 16'h8000; rTab[3] = 13'h1000; oTab[3] = 14'h2512; sTab[3] = 13'h1000;
    pTab[4] = {128'd0, 16'd63};      bTab[4] = 16'h0000; rTab[4] = 13'h0000; oTab[4] = 14'h0000; sTab[4] = 13'h0000;
    pTab[5] = {128'd0, 16'hFFFF};    bTab[5] = 16'h0000; rTab[5] = 13'h0000; oTab[5] = 14'h3FFF; sTab[5] = 13'h1FFF;
    pTab[6] = '0;                    bTab[6] = 16'd64;   rTab[6] = 13'h0000; oTab[6] = 14'h0001; sTab[6] = 13'h0001;
    pTab[7] = {128'd0, 16'd64};      bTab[7] = 16'hFFC0; rTab[7] = 13'h0003; oTab[7] = 14'h0003; sTab[7] = 13'h0003;
    for (int i = 0; i < 8; i++) begin
      drive_vec(1'b1, pTab[i], bTab[i], rTab[i]);
      step();
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL directed_%0d: scoreboard empty", i);
      end else begin
        e = sb.pop_front();
        if (e.o !== oTab[i] || e.s !== sTab[i]) begin
          errors++;
          $display("[TB] FAIL directed_%0d_model: model out=%h sat=%h, table out=%h sat=%h", i, e.o, e.s, oTab[i], sTab[i]);
        end
        if (out_valid !== 1'b1 || out !== e.o || out_sat !== e.s) begin
          errors++;
          $display("[TB] FAIL directed_%0d: got valid=%b out=%h sat=%h, want 1/%h/%h", i, out_valid, out, out_sat, e.o, e.s);
        end
      end
    end
  endtask

  task automatic test_sweep();
    logic signed [7:0]  a;
    logic signed [7:0]  b;
    logic signed [15:0] p;
    logic [15:0]        bs;
    exp_t               e;
    int                 bad;
    bs  = 16'h0000;
    bad = 0;
    for (int i = 0; i < 65536; i++) begin
      a  = 8'(i >> 8);
      b  = 8'(i);
      p  = 16'(a * b);
      bs = bs + 16'd5;
      drive_vec(1'b1, {9{p}}, bs, 13'($urandom_range(0, 8191)));
      step();
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL sweep_%0d: scoreboard empty", i);
      end else begin
        e = sb.pop_front();
        if (out_valid !== 1'b1 || out !== e.o || out_sat !== e.s) begin
          errors++;
          bad++;
          if (bad <= 20)
            $display("[TB] FAIL sweep_%0d: got valid=%b out=%h sat=%h, want 1/%h/%h", i, out_valid, out, out_sat, e.o, e.s);
        end
      end
    end
  endtask

  task automatic test_gap();
    exp_t e;
    drive_vec(1'b1, {9{16'h1234}}, 16'hF00D, 13'h0ABC);
    step();
    checks++;
    e = sb.pop_front();
    if (out_valid !== 1'b1 || out !== e.o || out_sat !== e.s) begin
      errors++;
      $display("[TB] FAIL gap_load: got valid=%b out=%h sat=%h, want 1/%h/%h", out_valid, out, out_sat, e.o, e.s);
    end
    for (int i = 0; i < 3; i++) begin
      drive_vec(1'b0, {9{16'h4000}}, 16'h7FFF, 13'h0FFF);
      step();
      checks++;
      if (out_valid !== 1'b0 || out !== e.o || out_sat !== e.s) begin
        errors++;
        $display("[TB] FAIL gap_hold_%0d: got valid=%b out=%h sat=%h, want 0/%h/%h", i, out_valid, out, out_sat, e.o, e.s);
      end
    end
  endtask

  task automatic test_back_to_back_reset();
    exp_t e;
    drive_vec(1'b1, {9{16'h0100}}, 16'h0040, 13'h0001);
    step();
    checks++;
    e = sb.pop_front();
    if (out_valid !== 1'b1 || out !== e.o || out_sat !== e.s) begin
      errors++;
      $display("[TB] FAIL pre_reset: got valid=%b out=%h sat=%h, want 1/%h/%h", out_valid, out, out_sat, e.o, e.s);
    end
    drive_vec(1'b1, {9{16'h2000}}, 16'h0000, 13'h0000);
    #2;
    reset = 1'b0;
    #1;
    sb.delete();
    checks++;
    if (out_valid !== 1'b0 || out !== 14'h0 || out_sat !== 13'h0) begin
      errors++;
      $display("[TB] FAIL async_reset: got valid=%b out=%h sat=%h, want 0/0/0", out_valid, out, out_sat);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || out !== 14'h0) begin
      errors++;
      $display("[TB] FAIL reset_held: got valid=%b out=%h, want 0/0", out_valid, out);
    end
    reset = 1'b1;
    drive_vec(1'b0, '0, '0, '0);
    step();
    checks++;
    if (out_valid !== 1'b0 || out !== 14'h0) begin
      errors++;
      $display("[TB] FAIL post_reset_idle: got valid=%b out=%h, want 0/0", out_valid, out);
    end
    drive_vec(1'b1, {9{16'hFF00}}, 16'h1234, 13'h1F00);
    step();
    checks++;
    e = sb.pop_front();
    if (out_valid !== 1'b1 || out !== e.o || out_sat !== e.s) begin
      errors++;
      $display("[TB] FAIL first_after_reset: got valid=%b out=%h sat=%h, want 1/%h/%h", out_valid, out, out_sat, e.o, e.s);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_gap();
    test_back_to_back_reset();
    test_sweep();
    drive_vec(1'b0, '0, '0, '0);
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
